// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone B4 arbiter family.
package wb_arb_pkg;

  localparam int MAX_M = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic int onehot_to_idx(input logic [MAX_M-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_M; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  // First requester at or after ptr, wrapping within n masters.
  function automatic logic [MAX_M-1:0] rr_pick(input logic [MAX_M-1:0] req,
                                               input int ptr, input int n);
    logic [MAX_M-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_M; i++) begin
      idx = (ptr + i) % n;
      if ((i < n) && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: one-hot winner among i_req starting at i_ptr.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NUM_M-1:0] o_gnt
);

  assign o_gnt = NUM_M'(rr_pick(MAX_M'(i_req), int'(i_ptr), NUM_M));

endmodule

// File: rtl/wb_b4_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 pipelined slave among NUM_M masters,
// with lock hold and outstanding-transfer limiting.
module wb_b4_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_M   = 2,
  parameter  int ADR_W   = 32,
  parameter  int DAT_W   = 64,
  parameter  int MAX_OUT = 4,
  localparam int SEL_W   = DAT_W / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_M-1:0]       m_cyc,
  input  logic [NUM_M-1:0]       m_stb,
  input  logic [NUM_M-1:0]       m_we,
  input  logic [NUM_M-1:0]       m_lock,
  input  logic [NUM_M*ADR_W-1:0] m_adr,
  input  logic [NUM_M*SEL_W-1:0] m_sel,
  input  logic [NUM_M*DAT_W-1:0] m_dat_w,
  output logic [DAT_W-1:0]       m_dat_r,
  output logic [NUM_M-1:0]       m_ack,
  output logic [NUM_M-1:0]       m_err,
  output logic [NUM_M-1:0]       m_rty,
  output logic [NUM_M-1:0]       m_stall,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic                   s_lock,
  output logic [ADR_W-1:0]       s_adr,
  output logic [SEL_W-1:0]       s_sel,
  output logic [DAT_W-1:0]       s_dat_w,
  input  logic [DAT_W-1:0]       s_dat_r,
  input  logic                   s_ack,
  input  logic                   s_err,
  input  logic                   s_rty,
  input  logic                   s_stall,
  output logic [NUM_M-1:0]       gnt
);

  localparam int               CNT_W    = $clog2(MAX_OUT + 1);
  localparam int               PTR_W    = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_M - 1);

  arb_state_t       r_state, w_state_nxt;
  logic [NUM_M-1:0] r_gnt, w_gnt_nxt, w_pick;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt, w_gidx;
  logic [CNT_W-1:0] r_out_cnt, w_out_cnt_nxt;
  logic             w_own, w_gcyc, w_glock, w_gstb, w_gwe;
  logic             w_full, w_cnt_nz, w_accept, w_term, w_release;

  wb_rr_pick #(
    .NUM_M(NUM_M),
    .PTR_W(PTR_W)
  ) u_pick (
    .i_req(m_cyc),
    .i_ptr(r_rr_ptr),
    .o_gnt(w_pick)
  );

  // Granted-master controls collapse to zero in IDLE because r_gnt is zero.
  assign w_own     = (r_state == OWN);
  assign w_gcyc    = |(m_cyc & r_gnt);
  assign w_glock   = |(m_lock & r_gnt);
  assign w_gstb    = |(m_stb & r_gnt);
  assign w_gwe     = |(m_we & r_gnt);
  assign w_gidx    = PTR_W'(onehot_to_idx(MAX_M'(r_gnt)));
  assign w_full    = (r_out_cnt == CNT_MAX);
  assign w_cnt_nz  = (r_out_cnt != '0);
  assign w_accept  = s_stb & ~s_stall;
  assign w_term    = (s_ack | s_err | s_rty) & w_cnt_nz;
  assign w_release = w_own & ~w_gcyc & ~w_glock;

  assign s_cyc   = w_gcyc;
  assign s_lock  = w_glock;
  assign s_we    = w_gwe;
  assign s_stb   = w_gstb & ~w_full;
  assign gnt     = r_gnt;
  assign m_dat_r = s_dat_r;
  assign m_ack   = r_gnt & {NUM_M{s_ack & w_cnt_nz}};
  assign m_err   = r_gnt & {NUM_M{s_err & w_cnt_nz}};
  assign m_rty   = r_gnt & {NUM_M{s_rty & w_cnt_nz}};
  assign m_stall = ~r_gnt | {NUM_M{s_stall | w_full}};

  always_comb begin
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_gnt[i]) begin
        s_adr   = m_adr[i*ADR_W +: ADR_W];
        s_sel   = m_sel[i*SEL_W +: SEL_W];
        s_dat_w = m_dat_w[i*DAT_W +: DAT_W];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (|m_cyc) begin
          w_state_nxt = OWN;
          w_gnt_nxt   = w_pick;
        end
      end
      OWN: begin
        if (w_release) begin
          w_state_nxt  = IDLE;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = (w_gidx == PTR_LAST) ? '0 : w_gidx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // Releasing the bus discards any outstanding count so late slave terminations are dropped.
  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    if (w_release) begin
      w_out_cnt_nxt = '0;
    end else if (w_accept && !w_term) begin
      w_out_cnt_nxt = r_out_cnt + 1'b1;
    end else if (w_term && !w_accept) begin
      w_out_cnt_nxt = r_out_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_rr_ptr  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_b4_arbiter.sv
// Directed bench for wb_b4_arbiter: per-cycle vector table plus hand-written
// pipeline-limit, lock, abort and async-reset sequences.
module tb_wb_b4_arbiter;

  localparam int NUM_M = 2;
  localparam int ADR_W = 32;
  localparam int DAT_W = 64;
  localparam int SEL_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_M-1:0]       mCyc, mStb, mWe, mLock;
  logic [NUM_M*ADR_W-1:0] mAdr;
  logic [NUM_M*SEL_W-1:0] mSel;
  logic [NUM_M*DAT_W-1:0] mDatW;
  logic [DAT_W-1:0]       mDatR;
  logic [NUM_M-1:0]       mAck, mErr, mRty, mStall;
  logic                   sCyc, sStb, sWe, sLock;
  logic [ADR_W-1:0]       sAdr;
  logic [SEL_W-1:0]       sSel;
  logic [DAT_W-1:0]       sDatW, sDatR;
  logic                   sAck, sErr, sRty, sStall;
  logic [NUM_M-1:0]       gnt;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [1:0]  lock;
    logic        ack;
    logic [1:0]  expGnt;
    logic        expCyc;
    logic        expStb;
    logic        expLock;
    logic [1:0]  expAck;
    logic [1:0]  expStall;
    logic [31:0] expAdr;
  } vec_t;

  vec_t vecs[18];

  wb_b4_arbiter #(
    .NUM_M(NUM_M), .ADR_W(ADR_W), .DAT_W(DAT_W), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(mCyc), .m_stb(mStb), .m_we(mWe), .m_lock(mLock),
    .m_adr(mAdr), .m_sel(mSel), .m_dat_w(mDatW), .m_dat_r(mDatR),
    .m_ack(mAck), .m_err(mErr), .m_rty(mRty), .m_stall(mStall),
    .s_cyc(sCyc), .s_stb(sStb), .s_we(sWe), .s_lock(sLock),
    .s_adr(sAdr), .s_sel(sSel), .s_dat_w(sDatW), .s_dat_r(sDatR),
    .s_ack(sAck), .s_err(sErr), .s_rty(sRty), .s_stall(sStall),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cyc, input logic [1:0] stb,
                               input logic [1:0] lock, input logic ack);
    mCyc  = cyc;
    mStb  = stb;
    mWe   = stb;
    mLock = lock;
    sAck  = ack;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] expDat;
    logic [7:0]  expSel;
    int          sent, acksSeen, pend, cyc;
    logic        ackNow;

    vecs[0]  = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 32'h000};
    vecs[1]  = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 32'h100};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 32'h100};
    vecs[3]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 32'h100};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 32'h000};
    vecs[5]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 32'h000};
    vecs[6]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 32'h200};
    vecs[7]  = '{2'b11, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 32'h200};
    vecs[8]  = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 32'h200};
    vecs[9]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 32'h000};
    vecs[10] = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 32'h100};
    vecs[11] = '{2'b11, 2'b10, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 32'h100};
    vecs[12] = '{2'b10, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 32'h100};
    vecs[13] = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 32'h000};
    vecs[14] = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 32'h200};
    vecs[15] = '{2'b11, 2'b01, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 32'h200};
    vecs[16] = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 32'h200};
    vecs[17] = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 32'h000};

    mAdr   = {32'h0000_0200, 32'h0000_0100};
    mDatW  = {64'h5A5A, 64'hA5A5};
    mSel   = {8'h0F, 8'hFF};
    sDatR  = '0;
    sErr   = 1'b0;
    sRty   = 1'b0;
    sStall = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);

    #12;
    checkOutput("reset gnt", gnt, 0);
    checkOutput("reset s_cyc", sCyc, 0);
    checkOutput("reset s_stb", sStb, 0);
    checkOutput("reset m_stall", mStall, 2'b11);
    checkOutput("reset s_adr", sAdr, 0);
    checkOutput("reset m_ack", mAck, 0);
    nextCycle;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].cyc, vecs[i].stb, vecs[i].lock, vecs[i].ack);
      sDatR = 64'hD000 + 64'(i);
      case (vecs[i].expGnt)
        2'b01:   begin expDat = 64'hA5A5; expSel = 8'hFF; end
        2'b10:   begin expDat = 64'h5A5A; expSel = 8'h0F; end
        default: begin expDat = 64'h0;    expSel = 8'h00; end
      endcase
      @(negedge clk);
      checkOutput($sformatf("vec%0d gnt", i), gnt, vecs[i].expGnt);
      checkOutput($sformatf("vec%0d s_cyc", i), sCyc, vecs[i].expCyc);
      checkOutput($sformatf("vec%0d s_stb", i), sStb, vecs[i].expStb);
      checkOutput($sformatf("vec%0d s_lock", i), sLock, vecs[i].expLock);
      checkOutput($sformatf("vec%0d m_ack", i), mAck, vecs[i].expAck);
      checkOutput($sformatf("vec%0d m_stall", i), mStall, vecs[i].expStall);
      checkOutput($sformatf("vec%0d s_adr", i), sAdr, vecs[i].expAdr);
      checkOutput($sformatf("vec%0d s_dat_w", i), sDatW, expDat);
      checkOutput($sformatf("vec%0d s_sel", i), sSel, expSel);
      checkOutput($sformatf("vec%0d m_dat_r", i), mDatR, 64'hD000 + 64'(i));
      nextCycle;
    end

    // Pipeline limit: six strobes from master 0 against a slave that acks late.
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("pipe idle gnt", gnt, 0);
    nextCycle;
    sent = 0; acksSeen = 0; pend = 0; cyc = 0;
    while (acksSeen < 6 && cyc < 30) begin
      ackNow = (cyc >= 6) && (pend > 0);
      applyStimulus(2'b01, (sent < 6) ? 2'b01 : 2'b00, 2'b00, ackNow);
      @(negedge clk);
      checkOutput("pipe no ack to master 1", mAck[1], 0);
      if (cyc == 5) begin
        checkOutput("pipe accepted before first ack", 64'(sent), 4);
        checkOutput("pipe stall at limit", mStall[0], 1);
        checkOutput("pipe stb held at limit", sStb, 0);
      end
      if (sStb && !sStall) begin
        sent++;
        pend++;
      end
      if (mAck[0]) acksSeen++;
      if (ackNow) pend--;
      cyc++;
      nextCycle;
    end
    checkOutput("pipe strobes accepted", 64'(sent), 6);
    checkOutput("pipe acks returned", 64'(acksSeen), 6);

    applyStimulus(2'b01, 2'b00, 2'b00, 1'b1);
    @(negedge clk);
    checkOutput("stray ack at zero count", mAck, 0);
    nextCycle;
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    nextCycle;

    // Lock hold: master 1 keeps lock with cyc low while master 0 waits.
    applyStimulus(2'b11, 2'b00, 2'b10, 1'b0);
    @(negedge clk);
    checkOutput("lock idle gnt", gnt, 0);
    nextCycle;
    applyStimulus(2'b11, 2'b00, 2'b10, 1'b0);
    @(negedge clk);
    checkOutput("lock owner gnt", gnt, 2'b10);
    checkOutput("lock owner s_lock", sLock, 1);
    nextCycle;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b01, 2'b00, 2'b10, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("lock hold%0d gnt", k), gnt, 2'b10);
      checkOutput($sformatf("lock hold%0d s_cyc", k), sCyc, 0);
      checkOutput($sformatf("lock hold%0d s_lock", k), sLock, 1);
      checkOutput($sformatf("lock hold%0d m_stall0", k), mStall[0], 1);
      nextCycle;
    end
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("lock drop s_lock", sLock, 0);
    nextCycle;
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("lock gap gnt", gnt, 0);
    nextCycle;

    // Abort: master 0 drops cyc with two transfers outstanding.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("abort gnt%0d", k), gnt, 2'b01);
      checkOutput($sformatf("abort stb%0d", k), sStb, 1);
      nextCycle;
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    nextCycle;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("abort late ack%0d", k), mAck, 0);
      nextCycle;
    end
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("regrant idle gnt", gnt, 0);
    nextCycle;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("regrant gnt%0d", k), gnt, 2'b01);
      checkOutput($sformatf("regrant stb%0d", k), sStb, 1);
      checkOutput($sformatf("regrant stall%0d", k), mStall[0], 0);
      nextCycle;
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, k < 3);
      sErr = (k == 3);
      @(negedge clk);
      if (k < 3) checkOutput($sformatf("drain ack%0d", k), mAck, 2'b01);
      else       checkOutput("drain err", mErr, 2'b01);
      nextCycle;
    end
    sErr = 1'b0;

    // Async reset between edges with a transfer in flight.
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    nextCycle;
    #1;
    checkOutput("mid-burst s_cyc before reset", sCyc, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset s_cyc", sCyc, 0);
    checkOutput("async reset gnt", gnt, 0);
    checkOutput("async reset m_stall", mStall, 2'b11);
    checkOutput("async reset s_stb", sStb, 0);
    checkOutput("async reset s_adr", sAdr, 0);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    nextCycle;
    rst_n = 1'b1;
    nextCycle;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
